// File: rtl/uart_pkg.sv
// Shared UART types and line-level constants for the TX path (and a future RX).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between an upstream byte producer and uart_tx.
interface uart_tx_if;

  logic [7:0] data_in;
  logic       valid_in;
  logic       ready;

  modport master (output data_in, output valid_in, input ready);
  modport slave  (input data_in, input valid_in, output ready);

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, pulses bit_done on the last count.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign bit_done = enable & (count == LAST_COUNT);

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= bit_done ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with registered tx and a valid/ready byte handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS != 8) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS is fixed at 8");
  end

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t            state, next_state;
  logic [DATA_BITS-1:0] shift_q, shift_next;
  logic [2:0]           bit_idx, bit_idx_next;
  logic                 tx_next;
  logic                 accept;
  logic                 bit_done;

`ifdef UART_TX_PARITY_EN
  logic parity_q;
`endif

  // ready depends only on registered state and reset, never on valid_in.
  assign bus.ready = (state == IDLE) & ~reset;
  assign accept    = bus.valid_in & bus.ready;
  assign busy      = (state != IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  (busy),
    .bit_done(bit_done)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state   = state;
    shift_next   = shift_q;
    bit_idx_next = bit_idx;

    case (state)
      IDLE: begin
        if (accept) begin
          next_state   = START;
          shift_next   = bus.data_in;
          bit_idx_next = '0;
        end
      end
      START: begin
        if (bit_done) next_state = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_next   = shift_q >> 1;
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            next_state = PARITY;
`else
            next_state = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) next_state = STOP;
      end
`endif
      STOP: begin
        if (bit_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    // tx is decoded from the upcoming state so the line changes on the same edge as the state.
    case (next_state)
      START:   tx_next = START_BIT;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_q;
`endif
      STOP:    tx_next = STOP_BIT;
      default: tx_next = IDLE_LEVEL;
    endcase
  end

  // NOTE: the shift register is reset along with control so tx never sees X after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_idx <= '0;
      tx      <= IDLE_LEVEL;
    end else begin
      state   <= next_state;
      shift_q <= shift_next;
      bit_idx <= bit_idx_next;
      tx      <= tx_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^bus.data_in;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=4; frames are compared against a bit-list model.
module tb_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME_CYCLES = FB * C;

  typedef logic [0:FB-1] frame_t;  // index 0 is the first bit on the line

`ifdef UART_TX_PARITY_EN
  localparam frame_t EXP_7B = 11'b01101111001;
  localparam frame_t EXP_0A = 11'b00101000001;
  localparam frame_t EXP_54 = 11'b00010101011;
`else
  localparam frame_t EXP_7B = 10'b0110111101;
  localparam frame_t EXP_0A = 10'b0010100001;
`endif

  logic clk;
  logic reset;
  logic tx;
  logic busy;
  int   checks;
  int   failures;

  uart_tx_if bus ();

  uart_tx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .tx   (tx),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] json [28] = '{
    8'h7B, 8'h22, 8'h54, 8'h22, 8'h3A, 8'h30, 8'h2C, 8'h22, 8'h4C, 8'h22,
    8'h3A, 8'h30, 8'h30, 8'h2E, 8'h30, 8'h30, 8'h2C, 8'h22, 8'h52, 8'h22,
    8'h3A, 8'h30, 8'h30, 8'h2E, 8'h30, 8'h30, 8'h7D, 8'h0A
  };

  // Reference frame: start bit, data LSB first, optional even parity, stop bit.
  function automatic frame_t model_frame(input logic [7:0] b);
    frame_t f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i + 1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    f[FB - 1] = 1'b1;
    return f;
  endfunction

  // Waits (bounded) for ready, presents a byte, and returns just after the accepting edge.
  task automatic start_frame(input logic [7:0] b, input logic hold_valid);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL start_timeout: ready=%b never rose, want 1", bus.ready);
    end
    bus.data_in  = b;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = hold_valid;
  endtask

  // Samples one frame's worth of cycles; a bit whose samples disagree is recorded as X.
  task automatic capture_frame(output frame_t bits, output int ready_low, output int busy_high,
                               output logic ready_after, output logic tx_after);
    logic first;
    logic same;
    ready_low = 0;
    busy_high = 0;
    for (int k = 0; k < FB; k++) begin
      first = 1'bx;
      same  = 1'b1;
      for (int s = 0; s < C; s++) begin
        @(negedge clk);
        if (s == 0) first = tx;
        else if (tx !== first) same = 1'b0;
        if (bus.ready === 1'b0) ready_low++;
        if (busy === 1'b1) busy_high++;
      end
      bits[k] = same ? first : 1'bx;
    end
    @(negedge clk);
    ready_after = bus.ready;
    tx_after    = tx;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || bus.ready !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: tx=%b ready=%b busy=%b, want 1 0 0", tx, bus.ready, busy);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: ready=%b busy=%b tx=%b, want 1 0 1", bus.ready, busy, tx);
    end
  endtask

  task automatic test_single_byte();
    frame_t bits;
    int     rl, bh;
    logic   ra, ta;
    start_frame(8'h7B, 1'b0);
    bus.data_in = 8'hA5;  // must not disturb the latched byte
    capture_frame(bits, rl, bh, ra, ta);
    checks++;
    if (bits !== EXP_7B) begin
      failures++;
      $display("FAIL single_frame: got %b want %b", bits, EXP_7B);
    end
    checks++;
    if (rl !== FRAME_CYCLES || bh !== FRAME_CYCLES) begin
      failures++;
      $display("FAIL single_len: ready_low=%0d busy_high=%0d want %0d", rl, bh, FRAME_CYCLES);
    end
    checks++;
    if (ra !== 1'b1 || ta !== 1'b1) begin
      failures++;
      $display("FAIL single_after: ready=%b tx=%b want 1 1", ra, ta);
    end
  endtask

  task automatic test_ignored_input();
    frame_t bits;
    int     rl, bh;
    logic   ra, ta;
    start_frame(8'h7B, 1'b1);
    bus.data_in = 8'hFF;  // valid stays high while the frame is in flight
    capture_frame(bits, rl, bh, ra, ta);
    checks++;
    if (bits !== model_frame(8'h7B)) begin
      failures++;
      $display("FAIL ignored_first: got %b want %b", bits, model_frame(8'h7B));
    end
    checks++;
    if (ra !== 1'b1 || ta !== 1'b1) begin
      failures++;
      $display("FAIL ignored_gap: ready=%b tx=%b want 1 1", ra, ta);
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    capture_frame(bits, rl, bh, ra, ta);
    checks++;
    if (bits !== model_frame(8'hFF)) begin
      failures++;
      $display("FAIL ignored_second: got %b want %b", bits, model_frame(8'hFF));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL ignored_no_extra: busy=%b tx=%b want 0 1", busy, tx);
    end
  endtask

  task automatic test_mid_frame_reset();
    frame_t bits;
    int     rl, bh;
    logic   ra, ta;
    start_frame(8'h54, 1'b0);
    repeat (C + 3 * C + 2) @(negedge clk);  // middle of data bit 3 (a zero)
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre: tx=%b busy=%b want 0 1", tx, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || bus.ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_abort: tx=%b busy=%b ready=%b want 1 0 0", tx, busy, bus.ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || tx !== 1'b1) begin
      failures++;
      $display("FAIL midreset_release: ready=%b tx=%b want 1 1", bus.ready, tx);
    end
    start_frame(8'h0A, 1'b0);
    capture_frame(bits, rl, bh, ra, ta);
    checks++;
    if (bits !== EXP_0A) begin
      failures++;
      $display("FAIL midreset_next: got %b want %b", bits, EXP_0A);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    frame_t bits;
    int     rl, bh;
    logic   ra, ta;
    start_frame(8'h54, 1'b0);
    capture_frame(bits, rl, bh, ra, ta);
    checks++;
    if (bits !== EXP_54) begin
      failures++;
      $display("FAIL parity_54: got %b want %b", bits, EXP_54);
    end
    start_frame(8'h22, 1'b0);
    capture_frame(bits, rl, bh, ra, ta);
    checks++;
    if (bits[9] !== 1'b0 || bits !== model_frame(8'h22)) begin
      failures++;
      $display("FAIL parity_22: got %b want %b", bits, model_frame(8'h22));
    end
    checks++;
    if (rl !== 44) begin
      failures++;
      $display("FAIL parity_len: ready_low=%0d want 44", rl);
    end
  endtask
`endif

  task automatic test_random();
    frame_t     bits;
    int         rl, bh;
    logic       ra, ta;
    logic [7:0] b;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_frame(b, 1'b0);
      capture_frame(bits, rl, bh, ra, ta);
      checks++;
      if (bits !== model_frame(b) || rl !== FRAME_CYCLES) begin
        failures++;
        $display("FAIL random_%0d: got %b len %0d want %b len %0d", i, bits, rl,
                 model_frame(b), FRAME_CYCLES);
      end
    end
  endtask

  // Streams the JSON command back to back with valid held high, as command_translator does.
  task automatic test_back_to_back();
    frame_t     bits;
    int         rl, bh;
    logic       ra, ta;
    logic [7:0] got;
    start_frame(json[0], 1'b1);
    for (int i = 0; i < 28; i++) begin
      if (i < 27) bus.data_in = json[i + 1];
      else bus.valid_in = 1'b0;
      capture_frame(bits, rl, bh, ra, ta);
      for (int j = 0; j < 8; j++) got[j] = bits[j + 1];
      checks++;
      if (got !== json[i] || bits !== model_frame(json[i]) || ra !== 1'b1 || ta !== 1'b1) begin
        failures++;
        $display("FAIL b2b_byte_%0d: got %h frame %b gap ready=%b tx=%b want %h frame %b gap 1 1",
                 i, got, bits, ra, ta, json[i], model_frame(json[i]));
      end
      if (i < 27) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (2 * C) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL b2b_no_extra: busy=%b tx=%b want 0 1", busy, tx);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_byte();
    test_ignored_input();
    test_mid_frame_reset();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
